// File: rtl/ifid_pkg.sv
// ifid_pkg: shared constants and types for the IF/ID stage buffer
package ifid_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h00001033;
    typedef enum logic {EMPTY, FULL} skid_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } ifid_payload_t;
endpackage

// File: rtl/ifid_stage_buf_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i)
        cnt_q <= !rst_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/ifid_stage_buf.sv
// ifid_stage_buf: valid-tagged IF/ID register with optional one-entry skid buffer and perf counters
module ifid_stage_buf import ifid_pkg::*; #(
    parameter int                 INSTR_W = 32,
    parameter int                 PC_W    = 32,
    parameter logic [INSTR_W-1:0] NOP     = NOP_INSTR,
    parameter bit                 SKID_EN = 1'b1,
    parameter int                 PERF_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               pred_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               stall_i,
    input  logic               mem_stall_i,
    input  logic               flush_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               pred_o,
    output logic               valid_o,
    output logic               skid_full_o,
    output logic [PERF_W-1:0]  stall_cnt_o,
    output logic [PERF_W-1:0]  flush_cnt_o
);
    logic hold, xfer, skid_full;
    skid_state_t state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d, sk_instr_q, sk_instr_d;
    logic [PC_W-1:0] pc_q, pc_d, sk_pc_q, sk_pc_d;
    logic pred_q, pred_d, sk_pred_q, sk_pred_d, valid_q, valid_d;
    assign hold      = stall_i | mem_stall_i;
    assign skid_full = SKID_EN && state_q == FULL;
    assign ready_o   = ~flush_i & (~hold | (SKID_EN && state_q == EMPTY));
    assign xfer      = valid_i & ready_o;
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pred_d     = pred_q;
        valid_d    = valid_q;
        sk_instr_d = sk_instr_q;
        sk_pc_d    = sk_pc_q;
        sk_pred_d  = sk_pred_q;
        state_d    = state_q;
        if (flush_i) begin
            instr_d = NOP;
            pc_d    = pc_i;
            pred_d  = 1'b0;
            valid_d = 1'b0;
            state_d = EMPTY;
        end else if (hold) begin
            if (xfer) begin
                sk_instr_d = instr_i;
                sk_pc_d    = pc_i;
                sk_pred_d  = pred_i;
                state_d    = FULL;
            end
        end else if (skid_full) begin
            instr_d = sk_instr_q;
            pc_d    = sk_pc_q;
            pred_d  = sk_pred_q;
            valid_d = 1'b1;
            state_d = xfer ? FULL : EMPTY;
            if (xfer) begin
                sk_instr_d = instr_i;
                sk_pc_d    = pc_i;
                sk_pred_d  = pred_i;
            end
        end else begin
            instr_d = xfer ? instr_i : NOP;
            valid_d = xfer;
            pc_d    = xfer ? pc_i : pc_q;
            pred_d  = xfer ? pred_i : pred_q;
        end
        if (!SKID_EN) state_d = EMPTY;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pred_q     <= 1'b0;
            valid_q    <= 1'b0;
            sk_instr_q <= NOP;
            sk_pc_q    <= '0;
            sk_pred_q  <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            valid_q    <= valid_d;
            sk_instr_q <= sk_instr_d;
            sk_pc_q    <= sk_pc_d;
            sk_pred_q  <= sk_pred_d;
            state_q    <= state_d;
        end
    end
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign pred_o      = pred_q;
    assign valid_o     = valid_q;
    assign skid_full_o = skid_full;
    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hold),
        .cnt_o (stall_cnt_o)
    );
    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_i),
        .cnt_o (flush_cnt_o)
    );
endmodule

// File: tb/tb_ifid_stage_buf.sv
// tb_ifid_stage_buf: directed tests of skid, no-skid and 4-bit-counter builds sharing one stimulus
module tb_ifid_stage_buf;
    localparam logic [31:0] NOPI = 32'h00001033;
    logic clk = 1'b0;
    logic rst_i, pred_i, valid_i, stall_i, mem_stall_i, flush_i;
    logic [31:0] instr_i, pc_i;
    logic [31:0] m_instr_o, m_pc_o, n_instr_o, n_pc_o, s_instr_o, s_pc_o;
    logic m_ready_o, m_pred_o, m_valid_o, m_skid_full_o;
    logic n_ready_o, n_pred_o, n_valid_o, n_skid_full_o;
    logic s_ready_o, s_pred_o, s_valid_o, s_skid_full_o;
    logic [15:0] m_stall_cnt_o, m_flush_cnt_o, n_stall_cnt_o, n_flush_cnt_o;
    logic [3:0] s_stall_cnt_o, s_flush_cnt_o;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ifid_stage_buf u_main (
        .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .pred_i(pred_i),
        .valid_i(valid_i), .ready_o(m_ready_o), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .instr_o(m_instr_o), .pc_o(m_pc_o), .pred_o(m_pred_o),
        .valid_o(m_valid_o), .skid_full_o(m_skid_full_o), .stall_cnt_o(m_stall_cnt_o),
        .flush_cnt_o(m_flush_cnt_o)
    );
    ifid_stage_buf #(.SKID_EN(1'b0)) u_noskid (
        .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .pred_i(pred_i),
        .valid_i(valid_i), .ready_o(n_ready_o), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .instr_o(n_instr_o), .pc_o(n_pc_o), .pred_o(n_pred_o),
        .valid_o(n_valid_o), .skid_full_o(n_skid_full_o), .stall_cnt_o(n_stall_cnt_o),
        .flush_cnt_o(n_flush_cnt_o)
    );
    ifid_stage_buf #(.PERF_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i), .pred_i(pred_i),
        .valid_i(valid_i), .ready_o(s_ready_o), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .instr_o(s_instr_o), .pc_o(s_pc_o), .pred_o(s_pred_o),
        .valid_o(s_valid_o), .skid_full_o(s_skid_full_o), .stall_cnt_o(s_stall_cnt_o),
        .flush_cnt_o(s_flush_cnt_o)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic ms, input logic fl);
        valid_i     = v;
        pc_i        = pc;
        instr_i     = instr_of(pc);
        pred_i      = pc[2];
        stall_i     = st;
        mem_stall_i = ms;
        flush_i     = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        total++; if (m_instr_o !== NOPI) begin bad++; $display("FAIL rst_instr got=%h exp=%h", m_instr_o, NOPI); end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", m_valid_o); end
        total++; if (m_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", m_pc_o); end
        total++; if (m_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", m_ready_o); end
        total++; if (m_skid_full_o !== 1'b0) begin bad++; $display("FAIL rst_skid got=%b exp=0", m_skid_full_o); end
        total++; if (m_stall_cnt_o !== 16'd0 || m_flush_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", m_stall_cnt_o, m_flush_cnt_o); end
    endtask

    task automatic test_stall_capture;
        drive(1, 32'h00, 0, 0, 0);
        tick();
        total++; if (m_pc_o !== 32'h00 || m_valid_o !== 1'b1) begin bad++; $display("FAIL cap_first got=%h/%b exp=00000000/1", m_pc_o, m_valid_o); end
        drive(1, 32'h04, 1, 0, 0);
        total++; if (m_ready_o !== 1'b1) begin bad++; $display("FAIL cap_ready_empty got=%b exp=1", m_ready_o); end
        tick();
        total++; if (m_skid_full_o !== 1'b1) begin bad++; $display("FAIL cap_skid_full got=%b exp=1", m_skid_full_o); end
        total++; if (m_pc_o !== 32'h00) begin bad++; $display("FAIL cap_frozen got=%h exp=00000000", m_pc_o); end
        drive(1, 32'h08, 1, 0, 0);
        total++; if (m_ready_o !== 1'b0) begin bad++; $display("FAIL cap_ready_full got=%b exp=0", m_ready_o); end
        tick();
        tick();
        total++; if (m_stall_cnt_o !== 16'd3) begin bad++; $display("FAIL cap_stall_cnt got=%0d exp=3", m_stall_cnt_o); end
        total++; if (s_stall_cnt_o !== 4'd3) begin bad++; $display("FAIL cap_stall_cnt4 got=%0d exp=3", s_stall_cnt_o); end
        total++; if (m_pc_o !== 32'h00 || m_valid_o !== 1'b1) begin bad++; $display("FAIL cap_hold_out got=%h/%b exp=00000000/1", m_pc_o, m_valid_o); end
        drive(1, 32'h08, 0, 0, 0);
        total++; if (m_ready_o !== 1'b1) begin bad++; $display("FAIL cap_ready_rel got=%b exp=1", m_ready_o); end
        tick();
        total++; if (m_pc_o !== 32'h04 || m_instr_o !== 32'hA000_0004 || m_pred_o !== 1'b1 || m_valid_o !== 1'b1)
            begin bad++; $display("FAIL cap_out4 got=%h/%h/%b/%b exp=00000004/a0000004/1/1", m_pc_o, m_instr_o, m_pred_o, m_valid_o); end
        total++; if (m_skid_full_o !== 1'b1) begin bad++; $display("FAIL cap_reload got=%b exp=1", m_skid_full_o); end
        drive(0, 32'h00, 0, 0, 0);
        tick();
        total++; if (m_pc_o !== 32'h08 || m_instr_o !== 32'hA000_0008 || m_pred_o !== 1'b0 || m_valid_o !== 1'b1)
            begin bad++; $display("FAIL cap_out8 got=%h/%h/%b/%b exp=00000008/a0000008/0/1", m_pc_o, m_instr_o, m_pred_o, m_valid_o); end
        total++; if (m_skid_full_o !== 1'b0) begin bad++; $display("FAIL cap_drain got=%b exp=0", m_skid_full_o); end
        tick();
        total++; if (m_valid_o !== 1'b0 || m_instr_o !== NOPI || m_pc_o !== 32'h08)
            begin bad++; $display("FAIL cap_no_repeat got=%b/%h/%h exp=0/00001033/00000008", m_valid_o, m_instr_o, m_pc_o); end
        total++; if (m_stall_cnt_o !== 16'd3) begin bad++; $display("FAIL cap_cnt_stays got=%0d exp=3", m_stall_cnt_o); end
    endtask

    task automatic test_flush_mem_stall;
        drive(1, 32'h10, 0, 0, 0);
        tick();
        drive(1, 32'h14, 0, 1, 0);
        tick();
        total++; if (m_skid_full_o !== 1'b1) begin bad++; $display("FAIL fl_setup_skid got=%b exp=1", m_skid_full_o); end
        drive(1, 32'h18, 0, 1, 1);
        total++; if (m_ready_o !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", m_ready_o); end
        tick();
        total++; if (m_instr_o !== NOPI || m_valid_o !== 1'b0 || m_pred_o !== 1'b0)
            begin bad++; $display("FAIL fl_out got=%h/%b/%b exp=00001033/0/0", m_instr_o, m_valid_o, m_pred_o); end
        total++; if (m_pc_o !== 32'h18) begin bad++; $display("FAIL fl_pc got=%h exp=00000018", m_pc_o); end
        total++; if (m_skid_full_o !== 1'b0) begin bad++; $display("FAIL fl_skid got=%b exp=0", m_skid_full_o); end
        total++; if (m_flush_cnt_o !== 16'd1) begin bad++; $display("FAIL fl_cnt got=%0d exp=1", m_flush_cnt_o); end
        total++; if (m_stall_cnt_o !== 16'd5) begin bad++; $display("FAIL fl_stall_cnt got=%0d exp=5", m_stall_cnt_o); end
        drive(0, 32'h00, 0, 0, 0);
        tick();
        total++; if (m_valid_o !== 1'b0 || m_instr_o !== NOPI)
            begin bad++; $display("FAIL fl_no_stale got=%b/%h exp=0/00001033", m_valid_o, m_instr_o); end
    endtask

    task automatic test_noskid;
        drive(1, 32'h20, 0, 0, 0);
        tick();
        total++; if (n_pc_o !== 32'h20 || n_valid_o !== 1'b1) begin bad++; $display("FAIL ns_first got=%h/%b exp=00000020/1", n_pc_o, n_valid_o); end
        drive(1, 32'h24, 1, 0, 0);
        total++; if (n_ready_o !== 1'b0) begin bad++; $display("FAIL ns_ready got=%b exp=0", n_ready_o); end
        tick();
        tick();
        total++; if (n_pc_o !== 32'h20 || n_instr_o !== 32'hA000_0020 || n_valid_o !== 1'b1)
            begin bad++; $display("FAIL ns_frozen got=%h/%h/%b exp=00000020/a0000020/1", n_pc_o, n_instr_o, n_valid_o); end
        total++; if (n_skid_full_o !== 1'b0) begin bad++; $display("FAIL ns_skid got=%b exp=0", n_skid_full_o); end
        drive(1, 32'h24, 0, 0, 0);
        total++; if (n_ready_o !== 1'b1) begin bad++; $display("FAIL ns_ready_rel got=%b exp=1", n_ready_o); end
        tick();
        total++; if (n_pc_o !== 32'h24 || n_instr_o !== 32'hA000_0024 || n_valid_o !== 1'b1)
            begin bad++; $display("FAIL ns_adv got=%h/%h/%b exp=00000024/a0000024/1", n_pc_o, n_instr_o, n_valid_o); end
        drive(0, 32'h00, 0, 0, 0);
        tick();
        total++; if (n_valid_o !== 1'b0 || n_instr_o !== NOPI || n_pc_o !== 32'h24)
            begin bad++; $display("FAIL ns_no_extra got=%b/%h/%h exp=0/00001033/00000024", n_valid_o, n_instr_o, n_pc_o); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pcs [3] = '{32'h30, 32'h34, 32'h38};
        for (int i = 0; i < 3; i++) begin
            drive(1, pcs[i], 0, 0, 0);
            tick();
            total++; if (m_pc_o !== pcs[i] || m_instr_o !== instr_of(pcs[i]) || m_valid_o !== 1'b1)
                begin bad++; $display("FAIL b2b_%0d got=%h/%h/%b exp=%h/%h/1", i, m_pc_o, m_instr_o, m_valid_o, pcs[i], instr_of(pcs[i])); end
        end
        drive(0, 32'h00, 0, 0, 0);
        tick();
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", m_valid_o); end
    endtask

    task automatic test_saturation;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        rst_i = 1'b1;
        drive(0, 0, 1, 0, 0);
        repeat (14) tick();
        total++; if (s_stall_cnt_o !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d exp=14", s_stall_cnt_o); end
        tick();
        total++; if (s_stall_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_15 got=%0d exp=15", s_stall_cnt_o); end
        repeat (5) tick();
        total++; if (s_stall_cnt_o !== 4'd15) begin bad++; $display("FAIL sat_held got=%0d exp=15", s_stall_cnt_o); end
        total++; if (m_stall_cnt_o !== 16'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", m_stall_cnt_o); end
        drive(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid_stall;
        drive(1, 32'h40, 0, 0, 0);
        tick();
        drive(1, 32'h44, 1, 0, 0);
        tick();
        total++; if (m_skid_full_o !== 1'b1) begin bad++; $display("FAIL rms_setup got=%b exp=1", m_skid_full_o); end
        rst_i = 1'b0;
        drive(1, 32'h48, 1, 0, 0);
        tick();
        total++; if (m_instr_o !== NOPI || m_pc_o !== 32'h0 || m_pred_o !== 1'b0 || m_valid_o !== 1'b0)
            begin bad++; $display("FAIL rms_out got=%h/%h/%b/%b exp=00001033/00000000/0/0", m_instr_o, m_pc_o, m_pred_o, m_valid_o); end
        total++; if (m_skid_full_o !== 1'b0) begin bad++; $display("FAIL rms_skid got=%b exp=0", m_skid_full_o); end
        total++; if (m_stall_cnt_o !== 16'd0 || m_flush_cnt_o !== 16'd0)
            begin bad++; $display("FAIL rms_cnts got=%0d/%0d exp=0/0", m_stall_cnt_o, m_flush_cnt_o); end
        rst_i = 1'b1;
        drive(0, 32'h00, 0, 0, 0);
        total++; if (m_ready_o !== 1'b1) begin bad++; $display("FAIL rms_ready got=%b exp=1", m_ready_o); end
        tick();
        total++; if (m_valid_o !== 1'b0 || m_instr_o !== NOPI || m_pc_o !== 32'h0)
            begin bad++; $display("FAIL rms_no_stale got=%b/%h/%h exp=0/00001033/00000000", m_valid_o, m_instr_o, m_pc_o); end
        tick();
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rms_no_stale2 got=%b exp=0", m_valid_o); end
    endtask

    initial begin
        test_reset();
        test_stall_capture();
        test_flush_mem_stall();
        test_noskid();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
